// File: rtl/game_logic_ctrl.sv
// game_logic_ctrl: cursor, piece selection and two-write move commit for a square board
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   board_input           board snapshot, square a at [a*PIECE_W +: PIECE_W]
//   BtnL/U/R/D/C          single-cycle debounced press pulses
//   board_out_addr/piece  board RAM write address/data, board_we write strobe
//   highlight_square_addr cursor square, selected_square_addr/selected_valid source square
//   turn, move_count      side to move (0 white), completed move count
module game_logic_ctrl #(
    parameter int BOARD_DIM = 8,
    parameter int PIECE_W = 4,
    parameter int WRAP = 0,
    localparam int ADDR_W = $clog2(BOARD_DIM * BOARD_DIM)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [BOARD_DIM*BOARD_DIM*PIECE_W-1:0] board_input,
    input  logic                             BtnL,
    input  logic                             BtnU,
    input  logic                             BtnR,
    input  logic                             BtnD,
    input  logic                             BtnC,
    output logic [ADDR_W-1:0]                board_out_addr,
    output logic [PIECE_W-1:0]               board_out_piece,
    output logic                             board_we,
    output logic [ADDR_W-1:0]                highlight_square_addr,
    output logic [ADDR_W-1:0]                selected_square_addr,
    output logic                             selected_valid,
    output logic                             turn,
    output logic [15:0]                      move_count
);
    localparam int RC_W = $clog2(BOARD_DIM);
    localparam bit CLAMP = (WRAP == 0);

    typedef enum logic [1:0] {IDLE, SELECTED, WRITE_DST, WRITE_SRC} state_t;

    state_t state_q, state_d;
    logic [RC_W-1:0] row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] src_q, src_d, addr_q, addr_d;
    logic [PIECE_W-1:0] src_piece_q, src_piece_d, piece_q, piece_d;
    logic sel_q, sel_d, turn_q, turn_d, we_q, we_d;
    logic [15:0] cnt_q, cnt_d;

    // Board dimension is a power of two, so {row,col} is row*BOARD_DIM+col
    // and plain modular arithmetic on row/col gives the wrap behaviour.
    logic [ADDR_W-1:0] cur;
    logic [PIECE_W-1:0] cur_piece;
    logic own;
    assign cur = {row_q, col_q};
    assign cur_piece = board_input[cur*PIECE_W +: PIECE_W];
    assign own = (cur_piece != '0) && (cur_piece[PIECE_W-1] == turn_q);

    always_comb begin
        state_d = state_q;
        row_d = row_q;
        col_d = col_q;
        src_d = src_q;
        src_piece_d = src_piece_q;
        sel_d = sel_q;
        turn_d = turn_q;
        cnt_d = cnt_q;
        we_d = 1'b0;
        addr_d = addr_q;
        piece_d = piece_q;
        case (state_q)
            IDLE, SELECTED: begin
                if (BtnC) begin
                    if (state_q == SELECTED && cur == src_q) begin
                        sel_d = 1'b0;
                        state_d = IDLE;
                    end else if (own) begin
                        src_d = cur;
                        src_piece_d = cur_piece;
                        sel_d = 1'b1;
                        state_d = SELECTED;
                    end else if (state_q == SELECTED) begin
                        // Destination write is launched here so board_we rises next cycle.
                        we_d = 1'b1;
                        addr_d = cur;
                        piece_d = src_piece_q;
                        state_d = WRITE_DST;
                    end
                end else if (BtnU) begin
                    row_d = (CLAMP && row_q == '0) ? row_q : row_q - RC_W'(1);
                end else if (BtnD) begin
                    row_d = (CLAMP && &row_q) ? row_q : row_q + RC_W'(1);
                end else if (BtnL) begin
                    col_d = (CLAMP && col_q == '0) ? col_q : col_q - RC_W'(1);
                end else if (BtnR) begin
                    col_d = (CLAMP && &col_q) ? col_q : col_q + RC_W'(1);
                end
            end
            WRITE_DST: begin
                we_d = 1'b1;
                addr_d = src_q;
                piece_d = '0;
                state_d = WRITE_SRC;
            end
            default: begin
                sel_d = 1'b0;
                turn_d = ~turn_q;
                cnt_d = cnt_q + 16'd1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q <= '0;
            col_q <= '0;
            src_q <= '0;
            src_piece_q <= '0;
            sel_q <= 1'b0;
            turn_q <= 1'b0;
            cnt_q <= '0;
            we_q <= 1'b0;
            addr_q <= '0;
            piece_q <= '0;
        end else begin
            state_q <= state_d;
            row_q <= row_d;
            col_q <= col_d;
            src_q <= src_d;
            src_piece_q <= src_piece_d;
            sel_q <= sel_d;
            turn_q <= turn_d;
            cnt_q <= cnt_d;
            we_q <= we_d;
            addr_q <= addr_d;
            piece_q <= piece_d;
        end
    end

    assign board_out_addr = addr_q;
    assign board_out_piece = piece_q;
    assign board_we = we_q;
    assign highlight_square_addr = cur;
    assign selected_square_addr = src_q;
    assign selected_valid = sel_q;
    assign turn = turn_q;
    assign move_count = cnt_q;
endmodule

// File: tb/tb_game_logic_ctrl.sv
// tb_game_logic_ctrl: directed bench for game_logic_ctrl (clamping and wrapping instances)
module tb_game_logic_ctrl;
    localparam logic [4:0] C = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010, R = 5'b00001;

    logic clk, rst_n;
    logic [255:0] board;
    logic bc, bu, bd, bl, br;
    logic [5:0] addr, hl, sel;
    logic [3:0] piece;
    logic we, valid, turn;
    logic [15:0] cnt;
    logic [5:0] addr1, hl1, sel1;
    logic [3:0] piece1;
    logic we1, valid1, turn1;
    logic [15:0] cnt1;
    int checks = 0;
    int errors = 0;

    game_logic_ctrl #(.BOARD_DIM(8), .PIECE_W(4), .WRAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .board_input(board),
        .BtnL(bl), .BtnU(bu), .BtnR(br), .BtnD(bd), .BtnC(bc),
        .board_out_addr(addr), .board_out_piece(piece), .board_we(we),
        .highlight_square_addr(hl), .selected_square_addr(sel), .selected_valid(valid),
        .turn(turn), .move_count(cnt)
    );

    game_logic_ctrl #(.BOARD_DIM(8), .PIECE_W(4), .WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .board_input(board),
        .BtnL(bl), .BtnU(bu), .BtnR(br), .BtnD(bd), .BtnC(bc),
        .board_out_addr(addr1), .board_out_piece(piece1), .board_we(we1),
        .highlight_square_addr(hl1), .selected_square_addr(sel1), .selected_valid(valid1),
        .turn(turn1), .move_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(input logic [4:0] b);
        @(negedge clk);
        {bc, bu, bd, bl, br} = b;
        @(negedge clk);
        {bc, bu, bd, bl, br} = 5'b0;
    endtask

    task automatic go_to(input int r, input int c);
        repeat (8) press(U);
        repeat (8) press(L);
        repeat (r) press(D);
        repeat (c) press(R);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        board = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (hl !== 6'd0) begin errors++; $display("FAIL reset_hl got %0d exp 0", hl); end
        checks++; if (sel !== 6'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
        checks++; if (turn !== 1'b0) begin errors++; $display("FAIL reset_turn got %0b exp 0", turn); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
        checks++; if ({we, addr, piece} !== 11'd0) begin errors++; $display("FAIL reset_wr got %0h exp 0", {we, addr, piece}); end
        checks++; if (hl1 !== 6'd0) begin errors++; $display("FAIL reset_hl_wrap got %0d exp 0", hl1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clamp_wrap();
        do_reset();
        press(U);
        checks++; if (hl !== 6'd0) begin errors++; $display("FAIL clamp_up got %0d exp 0", hl); end
        checks++; if (hl1 !== 6'd56) begin errors++; $display("FAIL wrap_up got %0d exp 56", hl1); end
        press(L);
        checks++; if (hl !== 6'd0) begin errors++; $display("FAIL clamp_left got %0d exp 0", hl); end
        checks++; if (hl1 !== 6'd63) begin errors++; $display("FAIL wrap_left got %0d exp 63", hl1); end
        press(R);
        checks++; if (hl1 !== 6'd56) begin errors++; $display("FAIL wrap_right got %0d exp 56", hl1); end
        press(D);
        checks++; if (hl1 !== 6'd0) begin errors++; $display("FAIL wrap_down got %0d exp 0", hl1); end
        go_to(7, 7);
        press(D);
        press(R);
        checks++; if (hl !== 6'd63) begin errors++; $display("FAIL clamp_br got %0d exp 63", hl); end
    endtask

    task automatic test_cursor();
        do_reset();
        press(D);
        checks++; if (hl !== 6'd8) begin errors++; $display("FAIL cur_down got %0d exp 8", hl); end
        press(D);
        press(R);
        checks++; if (hl !== 6'd17) begin errors++; $display("FAIL cur_dr got %0d exp 17", hl); end
        press(U);
        checks++; if (hl !== 6'd9) begin errors++; $display("FAIL cur_up got %0d exp 9", hl); end
        press(L);
        checks++; if (hl !== 6'd8) begin errors++; $display("FAIL cur_left got %0d exp 8", hl); end
    endtask

    task automatic test_move();
        do_reset();
        board[48*4 +: 4] = 4'h1;
        go_to(6, 0);
        checks++; if (hl !== 6'd48) begin errors++; $display("FAIL mv_hl got %0d exp 48", hl); end
        press(C);
        checks++; if ({valid, sel} !== {1'b1, 6'd48}) begin errors++; $display("FAIL mv_sel got %0b/%0d exp 1/48", valid, sel); end
        go_to(5, 0);
        press(C);
        checks++; if ({we, addr, piece} !== {1'b1, 6'd40, 4'h1}) begin errors++; $display("FAIL mv_wdst got %0b/%0d/%0h exp 1/40/1", we, addr, piece); end
        checks++; if (turn !== 1'b0) begin errors++; $display("FAIL mv_turn_mid got %0b exp 0", turn); end
        @(negedge clk);
        checks++; if ({we, addr, piece} !== {1'b1, 6'd48, 4'h0}) begin errors++; $display("FAIL mv_wsrc got %0b/%0d/%0h exp 1/48/0", we, addr, piece); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL mv_cnt_mid got %0d exp 0", cnt); end
        @(negedge clk);
        checks++; if ({we, addr, piece} !== {1'b0, 6'd48, 4'h0}) begin errors++; $display("FAIL mv_done_wr got %0b/%0d/%0h exp 0/48/0", we, addr, piece); end
        checks++; if ({turn, cnt, valid} !== {1'b1, 16'd1, 1'b0}) begin errors++; $display("FAIL mv_done got %0b/%0d/%0b exp 1/1/0", turn, cnt, valid); end
    endtask

    task automatic test_opponent();
        do_reset();
        board[10*4 +: 4] = 4'h9;
        go_to(1, 2);
        press(C);
        checks++; if ({valid, we} !== 2'b00) begin errors++; $display("FAIL opp_sel got %0b%0b exp 00", valid, we); end
        press(R);
        press(C);
        checks++; if ({valid, we} !== 2'b00) begin errors++; $display("FAIL opp_idle got %0b%0b exp 00", valid, we); end
        @(negedge clk);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL opp_nowr got %0b exp 0", we); end
    endtask

    task automatic test_deselect();
        do_reset();
        board[48*4 +: 4] = 4'h1;
        go_to(6, 0);
        press(C);
        press(C);
        checks++; if ({valid, we} !== 2'b00) begin errors++; $display("FAIL desel got %0b%0b exp 00", valid, we); end
        @(negedge clk);
        checks++; if ({we, cnt} !== 17'd0) begin errors++; $display("FAIL desel_nowr got %0b/%0d exp 0/0", we, cnt); end
    endtask

    task automatic test_reselect_capture();
        do_reset();
        board[48*4 +: 4] = 4'h1;
        board[49*4 +: 4] = 4'h2;
        board[10*4 +: 4] = 4'h9;
        go_to(6, 0);
        press(C);
        press(R);
        press(C);
        checks++; if ({valid, sel, we} !== {1'b1, 6'd49, 1'b0}) begin errors++; $display("FAIL resel got %0b/%0d/%0b exp 1/49/0", valid, sel, we); end
        go_to(1, 2);
        press(C);
        checks++; if ({we, addr, piece} !== {1'b1, 6'd10, 4'h2}) begin errors++; $display("FAIL cap_dst got %0b/%0d/%0h exp 1/10/2", we, addr, piece); end
        @(negedge clk);
        checks++; if ({we, addr, piece} !== {1'b1, 6'd49, 4'h0}) begin errors++; $display("FAIL cap_src got %0b/%0d/%0h exp 1/49/0", we, addr, piece); end
        @(negedge clk);
        checks++; if ({we, turn, cnt} !== {1'b0, 1'b1, 16'd1}) begin errors++; $display("FAIL cap_done got %0b/%0b/%0d exp 0/1/1", we, turn, cnt); end
        press(C);
        checks++; if ({valid, sel} !== {1'b1, 6'd10}) begin errors++; $display("FAIL black_sel got %0b/%0d exp 1/10", valid, sel); end
    endtask

    task automatic test_priority();
        do_reset();
        board[48*4 +: 4] = 4'h1;
        go_to(6, 0);
        press(C | R);
        checks++; if ({valid, sel, hl} !== {1'b1, 6'd48, 6'd48}) begin errors++; $display("FAIL pri_cr got %0b/%0d/%0d exp 1/48/48", valid, sel, hl); end
        press(U | R);
        checks++; if (hl !== 6'd40) begin errors++; $display("FAIL pri_ur got %0d exp 40", hl); end
        press(D | L);
        checks++; if (hl !== 6'd48) begin errors++; $display("FAIL pri_dl got %0d exp 48", hl); end
        press(L | R);
        checks++; if (hl !== 6'd48) begin errors++; $display("FAIL pri_lr got %0d exp 48", hl); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        board[48*4 +: 4] = 4'h1;
        go_to(6, 0);
        press(C);
        go_to(5, 0);
        press(C);
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL rmw_we got %0b exp 1", we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({we, addr, piece} !== 11'd0) begin errors++; $display("FAIL rmw_wr got %0h exp 0", {we, addr, piece}); end
        checks++; if ({hl, sel, valid, turn, cnt} !== 30'd0) begin errors++; $display("FAIL rmw_state got %0h exp 0", {hl, sel, valid, turn, cnt}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({we, turn, cnt} !== 18'd0) begin errors++; $display("FAIL rmw_after got %0h exp 0", {we, turn, cnt}); end
    endtask

    initial begin
        rst_n = 1'b1;
        board = '0;
        {bc, bu, bd, bl, br} = 5'b0;
        test_reset();
        test_clamp_wrap();
        test_cursor();
        test_move();
        test_opponent();
        test_deselect();
        test_reselect_capture();
        test_priority();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
